// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
//   Shared definitions for the vectoring-mode CORDIC unit (cordic_vec) and
//   its micro-rotation stage (cordic_vec_stage).
//
//   Contents:
//     fu_op            functional-unit opcode enum (ATAN2 / MAG added)
//     cordic_state_e   FSM state encoding of cordic_vec
//     atan_lut_t       packed table type for ATAN_LUT[0..29]
//     atan_lut(fb)     ATAN_LUT[i] = round(atan(2^-i) * 2^fb)
//     pi_fx(fb)        round(PI * 2^fb)
//     kinv_fx(fb)      round(0.6072529350 * 2^fb), inverse CORDIC gain
//
//   The constants are evaluated at elaboration time from a 100-fraction-bit
//   integer computation, so they are exact for every FRAC_BITS up to 61.
// -----------------------------------------------------------------------------
package cordic_pkg;

   typedef enum logic [7:0] {
      FU_NOP,
      ADD,
      SUB,
      MUL,
      DIV,
      SIN,
      COS,
      ATAN2,
      MAG
   } fu_op;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ITER,
      COMP,
      DONE
   } cordic_state_e;

   localparam int ATAN_LUT_LEN = 30;

   typedef logic [ATAN_LUT_LEN-1:0][63:0] atan_lut_t;

   // Working precision for the elaboration-time constant math.
   localparam int CALC_FB = 100;

   // PI * 2^100, truncated (25 hex fraction digits).
   localparam logic [127:0] PI_CALC = 128'h3_243F6A88_85A308D3_13198A2E_0;

   // Round a CALC_FB-scaled non-negative value to fb fractional bits.
   function automatic logic [63:0] round_to_fb(input logic [127:0] v, input int fb);
      return 64'((v + (128'd1 << (CALC_FB - fb - 1))) >> (CALC_FB - fb));
   endfunction

   // atan(2^-i) * 2^CALC_FB. i=0 is PI/4; otherwise the alternating series
   // t - t^3/3 + t^5/5 - ... with t = 2^-i, which converges at least 4x per term.
   function automatic logic [127:0] atan_pow2_calc(input int i);
      logic [127:0] acc;
      logic [127:0] term;
      if (i == 0) begin
         return PI_CALC >> 2;
      end
      acc = '0;
      for (int k = 1; k * i < CALC_FB; k += 2) begin
         term = (128'd1 << (CALC_FB - k * i)) / 128'(k);
         if (((k - 1) / 2) % 2 == 0) begin
            acc = acc + term;
         end else begin
            acc = acc - term;
         end
      end
      return acc;
   endfunction

   function automatic atan_lut_t atan_lut(input int fb);
      atan_lut_t lut;
      for (int i = 0; i < ATAN_LUT_LEN; i++) begin
         lut[i] = round_to_fb(atan_pow2_calc(i), fb);
      end
      return lut;
   endfunction

   function automatic logic [63:0] pi_fx(input int fb);
      return round_to_fb(PI_CALC, fb);
   endfunction

   function automatic logic [63:0] kinv_fx(input int fb);
      return 64'(((128'd6072529350 << fb) + 128'd5000000000) / 128'd10000000000);
   endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// -----------------------------------------------------------------------------
// cordic_vec_stage
//   One combinational vectoring-mode CORDIC micro-rotation. Drives y towards
//   zero while accumulating the rotated angle in z. Used iteratively by
//   cordic_vec; also suitable as one stage of an unrolled pipeline.
//
//   Parameters:
//     FRAC_BITS  fractional bits of x, y, z
//
//   Ports:
//     x_i, y_i   in   66  vector before the rotation (signed)
//     z_i        in   64  accumulated angle before the rotation (signed)
//     iter_i     in   5   micro-rotation index i (0..29)
//     x_o, y_o   out  66  vector after the rotation
//     z_o        out  64  accumulated angle after the rotation
// -----------------------------------------------------------------------------
module cordic_vec_stage
   import cordic_pkg::*;
#(
   parameter int FRAC_BITS = 32
) (
   input  logic signed [65:0] x_i,
   input  logic signed [65:0] y_i,
   input  logic signed [63:0] z_i,
   input  logic        [4:0]  iter_i,
   output logic signed [65:0] x_o,
   output logic signed [65:0] y_o,
   output logic signed [63:0] z_o
);

   localparam atan_lut_t ATAN_LUT = atan_lut(FRAC_BITS);

   logic signed [65:0] x_sh;
   logic signed [65:0] y_sh;
   logic signed [63:0] atan_v;
   logic               null_vec;

   always_comb begin
      x_sh     = x_i >>> iter_i;
      y_sh     = y_i >>> iter_i;
      atan_v   = ATAN_LUT[iter_i];
      // A zero vector has no angle; without this hold z would collect the
      // whole LUT sum because y==0 always picks the same direction.
      null_vec = (x_i == '0) && (y_i == '0);

      x_o = x_i;
      y_o = y_i;
      z_o = z_i;
      if (!y_i[65]) begin
         x_o = x_i + y_sh;
         y_o = y_i - x_sh;
         z_o = z_i + atan_v;
      end else begin
         x_o = x_i - y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - atan_v;
      end
      if (null_vec) begin
         z_o = z_i;
      end
   end

endmodule

// File: rtl/cordic_vec.sv
// -----------------------------------------------------------------------------
// cordic_vec
//   Iterative vectoring-mode CORDIC functional unit. Returns atan2(y, x) or
//   the magnitude of (x, y), one micro-rotation per cycle, one operation in
//   flight. Fixed-point format is signed Q(64-FRAC_BITS).FRAC_BITS, angles in
//   radians. Callers keep |x|,|y| <= 2^61 LSBs; there is no saturation.
//
//   Optional feature (macro CORDIC_GAIN_COMP_EN):
//     defined   -> a COMP cycle scales x by 1/K so MAG returns the true
//                  magnitude; both ops take one extra cycle.
//     undefined -> MAG returns x scaled by the CORDIC gain K ~= 1.6467602.
//
//   Parameters:
//     FRAC_BITS      fractional bits of operands and result
//     N_ITER         number of micro-rotations (1..30)
//     TRANS_ID_BITS  width of the transaction id
//
//   Ports:
//     clk_i        in   1   clock
//     rst_ni       in   1   synchronous active-low reset
//     flush_i      in   1   abort in-flight operation, blocks accept
//     valid_i      in   1   request valid
//     operation_i  in   fu_op  ATAN2 or MAG, other opcodes ignored
//     trans_id_i   in   TRANS_ID_BITS  request id
//     operand_a_i  in   64  x
//     operand_b_i  in   64  y
//     ready_o      out  1   idle, request can be accepted
//     valid_o      out  1   one-cycle result strobe
//     result_o     out  64  angle (ATAN2) or magnitude (MAG), held
//     trans_id_o   out  TRANS_ID_BITS  id of the returned result, held
// -----------------------------------------------------------------------------
module cordic_vec
   import cordic_pkg::*;
#(
   parameter int FRAC_BITS     = 32,
   parameter int N_ITER        = 16,
   parameter int TRANS_ID_BITS = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     valid_i,
   input  fu_op                     operation_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   input  logic [63:0]              operand_a_i,
   input  logic [63:0]              operand_b_i,
   output logic                     ready_o,
   output logic                     valid_o,
   output logic [63:0]              result_o,
   output logic [TRANS_ID_BITS-1:0] trans_id_o
);

   localparam logic signed [63:0] PI_FX     = pi_fx(FRAC_BITS);
   localparam logic        [4:0]  LAST_ITER = 5'(N_ITER - 1);

   cordic_state_e state_q, state_d;

   logic        [4:0]               iter_q, iter_d;
   logic signed [65:0]              x_q, x_d;
   logic signed [65:0]              y_q, y_d;
   logic signed [63:0]              z_q, z_d;
   fu_op                            op_q, op_d;
   logic        [TRANS_ID_BITS-1:0] id_q, id_d;
   logic                            valid_q, valid_d;
   logic        [63:0]              result_q, result_d;
   logic        [TRANS_ID_BITS-1:0] tid_q, tid_d;

   logic               op_ok;
   logic               accept;
   logic signed [65:0] x_rot;
   logic signed [65:0] y_rot;
   logic signed [63:0] z_rot;

`ifdef CORDIC_GAIN_COMP_EN
   localparam logic signed [63:0] KINV_FX = kinv_fx(FRAC_BITS);
   logic signed [129:0] x_gain;
   assign x_gain = 130'(x_q) * 130'(KINV_FX);
`endif

   assign op_ok  = (operation_i == ATAN2) || (operation_i == MAG);
   assign accept = valid_i && (state_q == IDLE) && op_ok && !flush_i;

   cordic_vec_stage #(
      .FRAC_BITS (FRAC_BITS)
   ) u_stage (
      .x_i    (x_q),
      .y_i    (y_q),
      .z_i    (z_q),
      .iter_i (iter_q),
      .x_o    (x_rot),
      .y_o    (y_rot),
      .z_o    (z_rot)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         iter_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         op_q     <= FU_NOP;
         id_q     <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         tid_q    <= '0;
      end else begin
         state_q  <= state_d;
         iter_q   <= iter_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         op_q     <= op_d;
         id_q     <= id_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         tid_q    <= tid_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (accept) state_d = PRE;
            PRE:  state_d = ITER;
            ITER: begin
               if (iter_q == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
                  state_d = COMP;
`else
                  state_d = DONE;
`endif
               end
            end
            COMP: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath and output next values
   always_comb begin
      iter_d   = iter_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      op_d     = op_q;
      id_d     = id_q;
      valid_d  = 1'b0;
      result_d = result_q;
      tid_d    = tid_q;
      if (!flush_i) begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  x_d    = {{2{operand_a_i[63]}}, operand_a_i};
                  y_d    = {{2{operand_b_i[63]}}, operand_b_i};
                  z_d    = '0;
                  iter_d = '0;
                  op_d   = operation_i;
                  id_d   = trans_id_i;
               end
            end
            PRE: begin
               // Left half-plane: rotate by PI so the iterations only need
               // to cover (-PI/2, PI/2); the PI sign follows the input y.
               if (x_q[65]) begin
                  x_d = -x_q;
                  y_d = -y_q;
                  z_d = y_q[65] ? -PI_FX : PI_FX;
               end else begin
                  z_d = '0;
               end
               iter_d = '0;
            end
            ITER: begin
               x_d    = x_rot;
               y_d    = y_rot;
               z_d    = z_rot;
               iter_d = iter_q + 5'd1;
            end
            COMP: begin
`ifdef CORDIC_GAIN_COMP_EN
               x_d = x_gain[FRAC_BITS+65:FRAC_BITS];
`endif
            end
            DONE: begin
               valid_d  = 1'b1;
               result_d = (op_q == ATAN2) ? z_q : x_q[63:0];
               tid_d    = id_q;
            end
            default: ;
         endcase
      end
   end

   // Outputs
   assign ready_o    = (state_q == IDLE);
   assign valid_o    = valid_q;
   assign result_o   = result_q;
   assign trans_id_o = tid_q;

endmodule

// File: tb/tb_cordic_vec.sv
// -----------------------------------------------------------------------------
// tb_cordic_vec
//   Directed self-checking bench for cordic_vec (FRAC_BITS=32, N_ITER=16).
//   Expected values are hand-computed fixed-point constants. Angle results
//   are allowed the CORDIC residual of atan(2^-(N_ITER-1)) plus LUT rounding.
// -----------------------------------------------------------------------------
module tb_cordic_vec;
   import cordic_pkg::*;

   localparam int FRAC_BITS = 32;
   localparam int N_ITER    = 16;
   localparam int TID_W     = 3;
   localparam int BUDGET    = 100;

`ifdef CORDIC_GAIN_COMP_EN
   localparam int                 LAT       = N_ITER + 3;
   localparam logic signed [63:0] MAG11_EXP = 64'sh1_6A09_E667;  // sqrt(2)
`else
   localparam int                 LAT       = N_ITER + 2;
   localparam logic signed [63:0] MAG11_EXP = 64'sh2_5430_DE96;  // K*sqrt(2)
`endif

   localparam logic signed [63:0] PI4_EXP   = 64'sh0_C90F_DAA2;
   localparam logic signed [63:0] PI_EXP    = 64'sh3_243F_6A89;
   localparam logic signed [63:0] M3PI4_EXP = -64'sh2_5B2F_8FE6;
   localparam longint             TOL_ANG   = (longint'(1) << (33 - N_ITER)) + 64;
   localparam longint             TOL_MAG   = longint'(1) << (32 - N_ITER);

   localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
   localparam logic [63:0] MONE = 64'hFFFF_FFFF_0000_0000;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             flush_i;
   logic             valid_i;
   fu_op             operation_i;
   logic [TID_W-1:0] trans_id_i;
   logic [63:0]      operand_a_i;
   logic [63:0]      operand_b_i;
   logic             ready_o;
   logic             valid_o;
   logic [63:0]      result_o;
   logic [TID_W-1:0] trans_id_o;

   int checks = 0;
   int errors = 0;

   cordic_vec #(
      .FRAC_BITS     (FRAC_BITS),
      .N_ITER        (N_ITER),
      .TRANS_ID_BITS (TID_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .operation_i (operation_i),
      .trans_id_i  (trans_id_i),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .ready_o     (ready_o),
      .valid_o     (valid_o),
      .result_o    (result_o),
      .trans_id_o  (trans_id_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end of test, required finish before 1ms");
      $fatal(1);
   end

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp, input longint tol);
      longint diff;
      diff = longint'(obs) - longint'(exp);
      if (diff < 0) diff = -diff;
      checks++;
      assert (diff <= tol) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h +/- %0d", tag, obs, exp, tol);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Issue one request, wait for its result, check latency, id and pulse width.
   task automatic run_op(input string tag, input fu_op op, input logic [63:0] a,
                         input logic [63:0] b, input logic [TID_W-1:0] id,
                         output logic [63:0] res);
      int lat;
      operation_i = op;
      operand_a_i = a;
      operand_b_i = b;
      trans_id_i  = id;
      valid_i     = 1'b1;
      tick();
      valid_i = 1'b0;
      lat = 0;
      while (!valid_o && lat < BUDGET) begin
         tick();
         lat++;
      end
      chk_eq({tag, "_lat"}, 64'(lat), 64'(LAT));
      chk_eq({tag, "_tid"}, 64'(trans_id_o), 64'(id));
      res = result_o;
      tick();
      chk_eq({tag, "_pulse"}, 64'(valid_o), 64'd0);
   endtask

   initial begin
      logic [63:0] res;
      int          n;
      int          gap;
      int          pulses;
      logic        busy_ok;
      logic        bad;

      rst_ni      = 1'b0;
      flush_i     = 1'b0;
      valid_i     = 1'b0;
      operation_i = FU_NOP;
      trans_id_i  = '0;
      operand_a_i = '0;
      operand_b_i = '0;
      repeat (2) tick();
      chk_eq("rst_ready", 64'(ready_o), 64'd1);
      chk_eq("rst_valid", 64'(valid_o), 64'd0);
      chk_eq("rst_result", result_o, 64'd0);
      chk_eq("rst_tid", 64'(trans_id_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      // First-quadrant diagonal
      run_op("atan_1_1", ATAN2, ONE, ONE, 3'd1, res);
      chk_tol("atan_1_1_val", res, PI4_EXP, TOL_ANG);
      run_op("mag_1_1", MAG, ONE, ONE, 3'd2, res);
      chk_tol("mag_1_1_val", res, MAG11_EXP, TOL_MAG);

      // Left half-plane folding
      run_op("atan_m1_0", ATAN2, MONE, 64'd0, 3'd3, res);
      chk_tol("atan_m1_0_val", res, PI_EXP, TOL_ANG);
      run_op("atan_m1_m1", ATAN2, MONE, MONE, 3'd4, res);
      chk_tol("atan_m1_m1_val", res, M3PI4_EXP, TOL_ANG);

      // Zero vector
      run_op("atan_0_0", ATAN2, 64'd0, 64'd0, 3'd5, res);
      chk_eq("atan_0_0_val", res, 64'd0);
      run_op("mag_0_0", MAG, 64'd0, 64'd0, 3'd6, res);
      chk_eq("mag_0_0_val", res, 64'd0);

      // Back-to-back: valid_i held high, second id waits for the first result
      operation_i = ATAN2;
      operand_a_i = ONE;
      operand_b_i = ONE;
      trans_id_i  = 3'd1;
      valid_i     = 1'b1;
      tick();
      trans_id_i = 3'd2;
      busy_ok = 1'b1;
      n = 0;
      while (!valid_o && n < BUDGET) begin
         if (ready_o) busy_ok = 1'b0;
         tick();
         n++;
      end
      chk_eq("b2b_busy", 64'(busy_ok), 64'd1);
      chk_eq("b2b_tid1", 64'(trans_id_o), 64'd1);
      gap = 0;
      do begin
         tick();
         gap++;
         if (gap == 1) valid_i = 1'b0;
      end while (!valid_o && gap < BUDGET);
      chk_eq("b2b_gap", 64'(gap), 64'(LAT + 1));
      chk_eq("b2b_tid2", 64'(trans_id_o), 64'd2);
      tick();

      // Flush at iteration 5, with a competing request in the same cycle
      operation_i = ATAN2;
      operand_a_i = ONE;
      operand_b_i = ONE;
      trans_id_i  = 3'd3;
      valid_i     = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (6) tick();
      flush_i    = 1'b1;
      valid_i    = 1'b1;
      trans_id_i = 3'd4;
      tick();
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk_eq("flush_ready", 64'(ready_o), 64'd1);
      chk_eq("flush_valid", 64'(valid_o), 64'd0);
      pulses = 0;
      repeat (LAT + 4) begin
         if (valid_o) pulses++;
         tick();
      end
      chk_eq("flush_no_result", 64'(pulses), 64'd0);
      run_op("post_flush", ATAN2, ONE, MONE, 3'd5, res);
      chk_tol("post_flush_val", res, -PI4_EXP, TOL_ANG);

      // Reset in the middle of the iterations
      operation_i = MAG;
      operand_a_i = ONE;
      operand_b_i = ONE;
      trans_id_i  = 3'd6;
      valid_i     = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (5) tick();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      chk_eq("mid_rst_ready", 64'(ready_o), 64'd1);
      chk_eq("mid_rst_valid", 64'(valid_o), 64'd0);
      chk_eq("mid_rst_result", result_o, 64'd0);
      chk_eq("mid_rst_tid", 64'(trans_id_o), 64'd0);
      pulses = 0;
      repeat (LAT + 4) begin
         if (valid_o) pulses++;
         tick();
      end
      chk_eq("mid_rst_no_result", 64'(pulses), 64'd0);

      // Unsupported opcode is never accepted
      operation_i = SIN;
      operand_a_i = ONE;
      operand_b_i = ONE;
      trans_id_i  = 3'd7;
      valid_i     = 1'b1;
      bad = 1'b0;
      repeat (LAT + 8) begin
         tick();
         if (!ready_o || valid_o) bad = 1'b1;
      end
      valid_i = 1'b0;
      chk_eq("sin_ignored", 64'(bad), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
